// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the registered N:1 channel multiplexer.
package mux_pkg;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Channel index width; a single bit is kept even for degenerate sizes.
    function automatic int sel_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction
endpackage

// File: rtl/mux_rr_arbiter.sv
// Round-robin request arbiter: first requester at or after the pointer wins.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SELW-1:0]     i_ptr,
    input  logic                i_en,
    output logic [CHANNELS-1:0] o_gnt,
    output logic [SELW-1:0]     o_idx
);
    logic            w_found;
    logic [SELW-1:0] w_idx;
    int              w_k;

    // Walk ptr, ptr+1, ... with a manual modulo so non-power-of-2 counts wrap correctly.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= CHANNELS) w_k = w_k - CHANNELS;
            w_idx = w_k[SELW-1:0];
            if (i_en && !w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx;
            end
        end
    end
endmodule

// File: rtl/mux_nx1_rr_reg.sv
// Registered N:1 valid/ready channel mux with round-robin or software-selected arbitration.
module mux_nx1_rr_reg
    import mux_pkg::*;
#(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter int  MODE     = MODE_RR,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk_311,
    input  logic                      rst_n_311,
    input  logic [CHANNELS*WIDTH-1:0] in_data_311,
    input  logic [CHANNELS-1:0]       in_valid_311,
    output logic [CHANNELS-1:0]       in_ready_311,
    input  logic [SELW-1:0]           sel_311,
    output logic [WIDTH-1:0]          out_data_311,
    output logic                      out_valid_311,
    input  logic                      out_ready_311,
    output logic [SELW-1:0]           out_chan_311
);
    logic [SELW-1:0]     r_ptr;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_chan;
    logic                w_load;
    logic [CHANNELS-1:0] w_rr_gnt;
    logic [CHANNELS-1:0] w_fix_gnt;
    logic [CHANNELS-1:0] w_gnt;
    logic [SELW-1:0]     w_rr_idx;
    logic [SELW-1:0]     w_idx;
    logic [WIDTH-1:0]    w_data;

    assign w_load = !r_out_valid || out_ready_311;

    mux_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .i_req (in_valid_311),
        .i_ptr (r_ptr),
        .i_en  (MODE == MODE_RR),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    // Out-of-range select values simply match no channel.
    always_comb begin
        w_fix_gnt = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_fix_gnt[k] = in_valid_311[k] && (sel_311 == k[SELW-1:0]);
    end

    always_comb begin
        if (MODE == MODE_RR) begin
            w_gnt = w_rr_gnt;
            w_idx = w_rr_idx;
        end else begin
            w_gnt = w_fix_gnt;
            w_idx = sel_311;
        end
        w_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (w_gnt[k]) w_data = in_data_311[k*WIDTH +: WIDTH];
    end

    assign in_ready_311 = (w_load && rst_n_311) ? w_gnt : '0;

    always_ff @(posedge clk_311 or negedge rst_n_311) begin
        if (!rst_n_311) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load) begin
            if (|w_gnt) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_chan  <= w_idx;
                if (MODE == MODE_RR)
                    r_ptr <= (w_idx == SELW'(CHANNELS-1)) ? '0 : w_idx + SELW'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data_311  = r_out_data;
    assign out_valid_311 = r_out_valid;
    assign out_chan_311  = r_out_chan;
endmodule
